multi_blinker: RTL and testbench

- Parametrised successor to the single-LED board blinker: CHANNELS independent LED blinkers, each with its own 2-bit rate mode.
- A shared 1 ms prescaler drives all channels, so periods are set in milliseconds, not raw cycles.
- Adds a global pause, a clean restart whenever a channel's mode changes, and an explicit off mode.
- Sits directly behind the board switches (MODE, ENABLE) and drives the LED bank.

---
 rtl/blink_pkg.sv | 31 +++
 rtl/blink_channel.sv | 79 +++++++
 rtl/multi_blinker.sv | 89 ++++++++
 tb/tb_multi_blinker.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared definitions for the multi-channel LED blinker: mode encodings,
// millisecond constant and a small sizing helper.
package blink_pkg;

  typedef logic [1:0] blink_mode_t;

  localparam blink_mode_t MODE_HALF0 = 2'd0;
  localparam blink_mode_t MODE_HALF1 = 2'd1;
  localparam blink_mode_t MODE_HALF2 = 2'd2;
  localparam blink_mode_t MODE_OFF   = 2'd3;

  localparam int MS_PER_S = 1000;

  // Largest of three half-periods, used to size the shared ms counters.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/blink_channel.sv
// One blink channel: millisecond counter, registered mode copy and LED state.
// Restarts cleanly on any mode change; mode MODE_OFF parks the channel dark.
module blink_channel
  import blink_pkg::*;
#(
  parameter int MS_W = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  blink_mode_t     mode,
  input  logic [MS_W-1:0] half_0,
  input  logic [MS_W-1:0] half_1,
  input  logic [MS_W-1:0] half_2,
  output logic            state
);

  logic [MS_W-1:0] cnt_r;
  logic [MS_W-1:0] cnt_s;
  blink_mode_t     mode_r;
  blink_mode_t     mode_s;
  logic            state_r;
  logic            state_s;
  logic [MS_W-1:0] half_s;
  logic [MS_W-1:0] last_s;

  // Select the half-period of the active mode.
  always_comb begin
    half_s = half_0;
    case (mode_r)
      MODE_HALF0: half_s = half_0;
      MODE_HALF1: half_s = half_1;
      MODE_HALF2: half_s = half_2;
      MODE_OFF:   half_s = half_0;
      default:    half_s = half_0;
    endcase
    last_s = half_s - {{(MS_W-1){1'b0}}, 1'b1};
  end

  // Next-state logic; a mode change takes priority and swallows a coincident tick.
  always_comb begin
    cnt_s   = cnt_r;
    mode_s  = mode_r;
    state_s = state_r;
    if (mode != mode_r) begin
      cnt_s   = {MS_W{1'b0}};
      state_s = 1'b0;
      mode_s  = mode;
    end else if (mode_r == MODE_OFF) begin
      cnt_s   = {MS_W{1'b0}};
      state_s = 1'b0;
    end else if (tick) begin
      if (cnt_r == last_s) begin
        cnt_s   = {MS_W{1'b0}};
        state_s = ~state_r;
      end else begin
        cnt_s   = cnt_r + {{(MS_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_s   = cnt_r;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= {MS_W{1'b0}};
      mode_r  <= MODE_HALF0;
      state_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_s;
      mode_r  <= mode_s;
      state_r <= state_s;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/multi_blinker.sv
// CHANNELS independent LED blinkers sharing a 1 ms prescaler, with global pause.
// Optional dimming PWM on lit phases is enabled by defining MULTI_BLINKER_PWM_EN.
module multi_blinker
  import blink_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int CHANNELS  = 8,
  parameter int HALF_MS_0 = 1000,
  parameter int HALF_MS_1 = 1800,
  parameter int HALF_MS_2 = 500,
  parameter int PWM_DUTY  = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic [2*CHANNELS-1:0] MODE,
  input  logic                  ENABLE,
  output logic [CHANNELS-1:0]   LED,
  output logic                  TICK_MS
);

  localparam int PRESC    = CLK_HZ / MS_PER_S;
  localparam int PRESC_W  = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int HALF_MAX = max3(HALF_MS_0, HALF_MS_1, HALF_MS_2);
  localparam int MS_W     = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
  localparam logic [MS_W-1:0]    HALF0_C    = MS_W'(HALF_MS_0);
  localparam logic [MS_W-1:0]    HALF1_C    = MS_W'(HALF_MS_1);
  localparam logic [MS_W-1:0]    HALF2_C    = MS_W'(HALF_MS_2);

  logic [PRESC_W-1:0]  presc_r;
  logic                tick_s;
  logic [CHANNELS-1:0] state_s;

  assign tick_s  = ENABLE && (presc_r == PRESC_LAST);
  assign TICK_MS = tick_s;

  // Millisecond prescaler; frozen while ENABLE is low.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      presc_r <= {PRESC_W{1'b0}};
    end else if (ENABLE) begin
      if (presc_r == PRESC_LAST) begin
        presc_r <= {PRESC_W{1'b0}};
      end else begin
        presc_r <= presc_r + {{(PRESC_W-1){1'b0}}, 1'b1};
      end
    end else begin
      presc_r <= presc_r;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    blink_channel #(
      .MS_W (MS_W)
    ) u_ch (
      .clk    (CLOCK_50),
      .reset  (RESET),
      .tick   (tick_s),
      .mode   (MODE[2*i +: 2]),
      .half_0 (HALF0_C),
      .half_1 (HALF1_C),
      .half_2 (HALF2_C),
      .state  (state_s[i])
    );
  end

`ifdef MULTI_BLINKER_PWM_EN
  localparam logic [4:0] DUTY_C = 5'(PWM_DUTY);

  logic [3:0] pwm_r;
  logic       pwm_on_s;

  // Free-running PWM phase counter.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      pwm_r <= 4'd0;
    end else begin
      pwm_r <= pwm_r + 4'd1;
    end
  end

  assign pwm_on_s = ({1'b0, pwm_r} < DUTY_C);
  assign LED      = state_s & {CHANNELS{pwm_on_s}};
`else
  assign LED = state_s;
`endif

endmodule

// File: tb/tb_multi_blinker.sv
// Directed bench for multi_blinker at PRESC=4, half-periods 10/18/5 ms, 4 channels.
module tb_multi_blinker;

  logic       CLOCK_50;
  logic       RESET;
  logic [7:0] MODE;
  logic       ENABLE;
  logic [3:0] LED;
  logic       TICK_MS;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  multi_blinker #(
    .CLK_HZ    (4000),
    .CHANNELS  (4),
    .HALF_MS_0 (10),
    .HALF_MS_1 (18),
    .HALF_MS_2 (5),
    .PWM_DUTY  (4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .MODE     (MODE),
    .ENABLE   (ENABLE),
    .LED      (LED),
    .TICK_MS  (TICK_MS)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int         test;
    int         cyc;
    logic [7:0] mode;
    logic [3:0] led;
    logic       tick;
  } vec_t;

  vec_t vecs[20];

  // Expected LED after optional PWM gating; PWM phase equals cycles since reset mod 16.
  function automatic logic [3:0] gate(input logic [3:0] s, input int c);
`ifdef MULTI_BLINKER_PWM_EN
    logic [3:0] ph;
    ph = c[3:0];
    return (ph < 4'd4) ? s : 4'd0;
`else
    return s;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset(input logic [7:0] m);
    RESET  = 1'b1;
    MODE   = m;
    ENABLE = 1'b1;
    step();
    RESET  = 1'b0;
    cyc    = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cur;
    RESET  = 1'b1;
    MODE   = 8'h00;
    ENABLE = 1'b1;

    // test 1: all mode 0; test 2: ch3..ch0 = off, 5 ms, 18 ms, 10 ms
    vecs[0]  = '{1,   0, 8'h00, 4'b0000, 1'b0};
    vecs[1]  = '{1,   3, 8'h00, 4'b0000, 1'b1};
    vecs[2]  = '{1,   4, 8'h00, 4'b0000, 1'b0};
    vecs[3]  = '{1,  39, 8'h00, 4'b0000, 1'b1};
    vecs[4]  = '{1,  40, 8'h00, 4'b1111, 1'b0};
    vecs[5]  = '{1,  79, 8'h00, 4'b1111, 1'b1};
    vecs[6]  = '{1,  80, 8'h00, 4'b0000, 1'b0};
    vecs[7]  = '{2,  19, 8'hE4, 4'b0000, 1'b1};
    vecs[8]  = '{2,  20, 8'hE4, 4'b0100, 1'b0};
    vecs[9]  = '{2,  39, 8'hE4, 4'b0100, 1'b1};
    vecs[10] = '{2,  40, 8'hE4, 4'b0001, 1'b0};
    vecs[11] = '{2,  60, 8'hE4, 4'b0101, 1'b0};
    vecs[12] = '{2,  71, 8'hE4, 4'b0101, 1'b1};
    vecs[13] = '{2,  72, 8'hE4, 4'b0111, 1'b0};
    vecs[14] = '{2,  80, 8'hE4, 4'b0010, 1'b0};
    vecs[15] = '{2, 100, 8'hE4, 4'b0110, 1'b0};
    vecs[16] = '{2, 120, 8'hE4, 4'b0011, 1'b0};
    vecs[17] = '{2, 140, 8'hE4, 4'b0111, 1'b0};
    vecs[18] = '{2, 143, 8'hE4, 4'b0111, 1'b1};
    vecs[19] = '{2, 144, 8'hE4, 4'b0101, 1'b0};

    cur = 0;
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].test != cur) begin
        cur = vecs[i].test;
        do_reset(vecs[i].mode);
      end
      run_to(vecs[i].cyc);
      chk($sformatf("vec%0d_led", i), {28'd0, LED}, {28'd0, gate(vecs[i].led, cyc)});
      chk($sformatf("vec%0d_tick", i), {31'd0, TICK_MS}, {31'd0, vecs[i].tick});
    end

    // Pause for 100 cycles starting after cycle 20: no ticks, LEDs frozen, rise slips to 140.
    do_reset(8'h00);
    run_to(20);
    ENABLE = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step();
      chk("pause_tick", {31'd0, TICK_MS}, 32'd0);
      chk("pause_led", {28'd0, LED}, 32'd0);
    end
    ENABLE = 1'b1;
    run_to(123);
    chk("resume_tick", {31'd0, TICK_MS}, 32'd1);
    run_to(139);
    chk("resume_led_139", {28'd0, LED}, {28'd0, gate(4'b0000, cyc)});
    run_to(140);
    chk("resume_led_140", {28'd0, LED}, {28'd0, gate(4'b1111, cyc)});

    // ch0 switches to 5 ms on a tick edge: that tick is dropped, rise at 52 not 48.
    do_reset(8'h00);
    run_to(31);
    chk("mc_tick_31", {31'd0, TICK_MS}, 32'd1);
    MODE = 8'h02;
    run_to(32);
    chk("mc_led_32", {28'd0, LED}, {28'd0, gate(4'b0000, cyc)});
    run_to(40);
    chk("mc_led_40", {28'd0, LED}, {28'd0, gate(4'b1110, cyc)});
    run_to(48);
    chk("mc_led_48", {28'd0, LED}, {28'd0, gate(4'b1110, cyc)});
    run_to(51);
    chk("mc_led_51", {28'd0, LED}, {28'd0, gate(4'b1110, cyc)});
    run_to(52);
    chk("mc_led_52", {28'd0, LED}, {28'd0, gate(4'b1111, cyc)});
    run_to(54);
    MODE = 8'h00;
    run_to(55);
    chk("mc_led_55", {28'd0, LED}, {28'd0, gate(4'b1110, cyc)});

    // Reset pulse while lit at cycle 60: immediate dark, full period afterwards.
    do_reset(8'h00);
    run_to(60);
    chk("rst_led_60", {28'd0, LED}, {28'd0, gate(4'b1111, cyc)});
    RESET = 1'b1;
    step();
    chk("rst_led", {28'd0, LED}, 32'd0);
    chk("rst_tick", {31'd0, TICK_MS}, 32'd0);
    RESET = 1'b0;
    cyc   = 0;
    run_to(39);
    chk("rst_led_39", {28'd0, LED}, {28'd0, gate(4'b0000, cyc)});
    run_to(40);
    chk("rst_led_40", {28'd0, LED}, {28'd0, gate(4'b1111, cyc)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
